// File: rtl/uart_tx_arbiter_if.sv
// Bundles the requester valid/ready/data lanes and the uart_tx empty/data/busy link.
// master = byte producers plus uart_tx; slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tx_empty;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_busy;

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_empty, tx_data
  );

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_empty, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one uart_tx from NUM_REQ byte producers, with a
// start timeout that drops a byte the transmitter never picks up.
module uart_tx_arbiter #(
  parameter int  NUM_REQ       = 4,
  parameter int  DATA_WIDTH    = 8,
  parameter int  START_TIMEOUT = 16,
  localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int TW            = $clog2(START_TIMEOUT)
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_tx_arbiter_if.slave       bus,
  output logic [GW-1:0]          grant_id,
  output logic                   busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {IDLE, PRESENT, WAIT_DONE} state_t;

  state_t                 state_reg, state_next;
  logic [GW-1:0]          ptr_reg, ptr_next;
  logic [GW-1:0]          grant_reg, grant_next;
  logic [DATA_WIDTH-1:0]  data_reg, data_next;
  logic [TW-1:0]          timer_reg, timer_next;
  logic                   terr_reg, terr_next;
  logic [GW-1:0]          winner, cand, grant_inc;
  logic                   found;
  logic [NUM_REQ-1:0]     ready_vec;
  logic [DATA_WIDTH-1:0]  req_bytes [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_bytes[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
    if (NUM_REQ == 1) begin : g_single
      assign grant_inc = '0;
    end else begin : g_multi
      assign grant_inc = (grant_reg == GW'(NUM_REQ-1)) ? '0 : grant_reg + GW'(1);
    end
  endgenerate

  // Scan from the farthest candidate back to ptr so the nearest valid one wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      cand = GW'((int'(ptr_reg) + k) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    ready_vec = '0;
    if (reset && state_reg == IDLE && found) ready_vec[winner] = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    data_next  = data_reg;
    timer_next = timer_reg;
    terr_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          data_next  = req_bytes[winner];
          grant_next = winner;
          timer_next = '0;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        // A busy rise on the final timeout cycle still counts as a start.
        if (bus.tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timer_reg == TW'(START_TIMEOUT-1)) begin
          terr_next  = 1'b1;
          ptr_next   = grant_inc;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          ptr_next   = grant_inc;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      grant_reg <= '0;
      data_reg  <= '0;
      timer_reg <= '0;
      terr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      data_reg  <= data_next;
      timer_reg <= timer_next;
      terr_reg  <= terr_next;
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.tx_empty  = (state_reg != PRESENT);
  assign bus.tx_data   = data_reg;
  assign grant_id      = grant_reg;
  assign busy          = (state_reg != IDLE);
  assign timeout_err   = terr_reg;

endmodule
